// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: one requester port (handshake, request fields and response) of the access controller
interface dm_access_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;
  modport master (output req, we, size, addr, wdata, input ack, err, rdata);
  modport slave (input req, we, size, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: two-port round-robin data memory access controller with read-modify-write for sub-word stores
module dm_access_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  dm_access_ctrl_if.slave p0,
  dm_access_ctrl_if.slave p1,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [AW-1:0] LAST_OK = {{(AW-2){1'b1}}, 2'b00};
  state_t state, next;
  logic any, gnt, oor, fill;
  logic g_we;
  logic [1:0] g_size;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic id, last, we;
  logic [1:0] size;
  logic [DW-1:0] wdata, rbuf, rd;
  logic err0, err1;
  logic [DW-1:0] rdata0, rdata1;

  function automatic logic [DW-1:0] fmt(input logic [1:0] sz, input logic [DW-1:0] w);
    return sz == 2'b00 ? {{(DW-8){1'b0}}, w[7:0]} : sz == 2'b01 ? {{(DW-16){1'b0}}, w[15:0]} : w;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [1:0] sz, input logic [DW-1:0] r, input logic [DW-1:0] w);
    return sz == 2'b00 ? {r[DW-1:8], w[7:0]} : sz == 2'b01 ? {r[DW-1:16], w[15:0]} : w;
  endfunction

  // Tie goes to the port not granted last; a lone requester wins outright.
  always_comb begin
    any = p0.req | p1.req;
    gnt = (p0.req & p1.req) ? ~last : p1.req;
    g_we = gnt ? p1.we : p0.we;
    g_size = gnt ? p1.size : p0.size;
    g_addr = gnt ? p1.addr : p0.addr;
    g_wdata = gnt ? p1.wdata : p0.wdata;
    oor = g_addr > LAST_OK;
    fill = (state == READ && !we) || state == WRITE;
    rd = fmt(size, state == READ ? mem_rdata : rbuf);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state == IDLE  ? (any ? (oor ? RESP : READ) : IDLE) :
           state == READ  ? (we ? WRITE : RESP) :
           state == WRITE ? RESP : IDLE;
  end

  always_comb begin
    mem_we = state == WRITE;
    busy = state != IDLE;
    p0.ack = state == RESP && !id;
    p1.ack = state == RESP && id;
    p0.err = err0;
    p1.err = err1;
    p0.rdata = rdata0;
    p1.rdata = rdata1;
  end

  // Response fields are loaded on the edge entering RESP and cleared otherwise, so they are nonzero only alongside ack.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      id <= 1'b0;
      last <= 1'b1;
      we <= 1'b0;
      size <= '0;
      wdata <= '0;
      rbuf <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (state == IDLE && any) begin
        id <= gnt;
        we <= g_we;
        size <= g_size;
        mem_addr <= g_addr;
        wdata <= g_wdata;
      end
      if (state == READ) begin
        rbuf <= mem_rdata;
        mem_wdata <= merge(size, mem_rdata, wdata);
      end
      if (state == RESP) last <= id;
      err0 <= state == IDLE && any && oor && !gnt;
      err1 <= state == IDLE && any && oor && gnt;
      rdata0 <= fill && !id ? rd : '0;
      rdata1 <= fill && id ? rd : '0;
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: bench for dm_access_ctrl with a byte-array memory behind the word port
module tb_dm_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_we, busy;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  dm_access_ctrl_if #(.AW(10), .DW(32)) p0 ();
  dm_access_ctrl_if #(.AW(10), .DW(32)) p1 ();

  dm_access_ctrl #(.AW(10), .DW(32)) dut (
    .clk(clk), .reset(reset), .p0(p0), .p1(p1), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dmem [1024] = '{default: 8'h00};
  logic [7:0] ref_mem [1024] = '{default: 8'h00};
  assign mem_rdata = {dmem[mem_addr + 10'd3], dmem[mem_addr + 10'd2], dmem[mem_addr + 10'd1], dmem[mem_addr]};
  always @(posedge clk) if (mem_we) for (int i = 0; i < 4; i++) dmem[mem_addr + 10'(i)] <= mem_wdata[8*i +: 8];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] size, input logic [9:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1.req = req; p1.we = we; p1.size = size; p1.addr = addr; p1.wdata = wdata;
    end else begin
      p0.req = req; p0.we = we; p0.size = size; p0.addr = addr; p0.wdata = wdata;
    end
  endtask

  int lat, we_cyc, we_n, oa;
  logic [31:0] we_word, rd;
  logic er;
  task automatic access(input bit port, input bit we, input logic [1:0] size, input logic [9:0] addr, input logic [31:0] wdata, input bit hold);
    @(negedge clk);
    drive(port, 1'b1, we, size, addr, wdata);
    lat = 0; we_cyc = 0; we_n = 0; we_word = 0; oa = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold && lat == 1) drive(port, 1'b0, we, size, addr, wdata);
      if (mem_we) begin we_n++; we_cyc = lat; we_word = mem_wdata; end
      if (port ? p0.ack : p1.ack) oa++;
    end while (!(port ? p1.ack : p0.ack) && lat < 20);
    rd = port ? p1.rdata : p0.rdata;
    er = port ? p1.err : p0.err;
    drive(port, 1'b0, we, size, addr, wdata);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [9:0] a, input logic [1:0] sz);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    return v;
  endfunction

  function automatic void ref_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endfunction

  typedef struct {
    bit v;
    int start;
    bit we;
    logic [1:0] size;
    logic [9:0] addr;
    logic [31:0] wdata;
  } rq_t;
  rq_t rq[2];
  int gap[2];
  int free, last_w, we_seen, we_exp;

  // Transaction-level prediction: the controller frees up two edges after a response and grants round-robin among waiting ports.
  task automatic monitor();
    int s0, s1, g, w, e;
    bit oor;
    logic a0, a1;
    a0 = p0.ack; a1 = p1.ack;
    if (mem_we) we_seen++;
    if (a0 | a1) chk("rnd_single_ack", a0 & a1, 1'b0);
    for (int k = 0; k < 2; k++) if (k == 1 ? a1 : a0) begin
      chk("rnd_ack_pending", rq[k].v, 1'b1);
      s0 = rq[0].v ? rq[0].start : 32'h3fffffff;
      s1 = rq[1].v ? rq[1].start : 32'h3fffffff;
      g = s0 < s1 ? s0 : s1;
      if (g < free) g = free;
      w = (s0 <= g && s1 <= g) ? 1 - last_w : (s0 <= g ? 0 : 1);
      e = g + (rq[w].addr > 10'd1020 ? 0 : rq[w].we ? 2 : 1);
      chk("rnd_grant_port", k, w);
      chk("rnd_ack_cycle", cyc, e);
      oor = rq[k].addr > 10'd1020;
      chk("rnd_err", k == 1 ? p1.err : p0.err, oor);
      if (oor || !rq[k].we) chk("rnd_rdata", k == 1 ? p1.rdata : p0.rdata, oor ? 32'h0 : ref_load(rq[k].addr, rq[k].size));
      else begin
        ref_store(rq[k].addr, rq[k].size, rq[k].wdata);
        we_exp++;
      end
      last_w = k;
      free = cyc + 2;
      rq[k].v = 0;
      gap[k] = $urandom_range(0, 3);
      drive(k[0], 1'b0, rq[k].we, rq[k].size, rq[k].addr, rq[k].wdata);
    end
  endtask

  int n, dual, t, idle_n, diffs, r;
  int ack_t[3];
  logic [3:0] seq;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", {p0.ack, p1.ack}, 2'b00);
    chk("rst_err", {p0.err, p1.err}, 2'b00);
    reset = 1'b0;

    access(1'b0, 1'b1, 2'd2, 10'h010, 32'hDEADBEEF, 1'b1);
    chk("sw_lat", lat, 3); chk("sw_we_cyc", we_cyc, 2); chk("sw_we_n", we_n, 1);
    chk("sw_wdata", we_word, 32'hDEADBEEF); chk("sw_err", er, 1'b0);
    access(1'b0, 1'b0, 2'd2, 10'h010, 32'h0, 1'b1);
    chk("lw_lat", lat, 2); chk("lw_rdata", rd, 32'hDEADBEEF); chk("lw_we_n", we_n, 0);
    access(1'b1, 1'b1, 2'd3, 10'h020, 32'h11223344, 1'b1);
    chk("p1_sw_lat", lat, 3); chk("p1_sw_other_ack", oa, 0);
    access(1'b1, 1'b1, 2'd0, 10'h020, 32'h000000AB, 1'b1);
    chk("sb_wdata", we_word, 32'h112233AB); chk("sb_lat", lat, 3);
    access(1'b1, 1'b0, 2'd0, 10'h020, 32'h0, 1'b1);
    chk("lb_rdata", rd, 32'h000000AB);
    access(1'b1, 1'b0, 2'd1, 10'h020, 32'h0, 1'b1);
    chk("lh_rdata", rd, 32'h000033AB);
    access(1'b0, 1'b1, 2'd2, 10'h3FE, 32'h12345678, 1'b1);
    chk("oor_lat", lat, 1); chk("oor_err", er, 1'b1); chk("oor_rdata", rd, 32'h0); chk("oor_we_n", we_n, 0);
    access(1'b0, 1'b1, 2'd2, 10'h3FC, 32'h55667788, 1'b1);
    chk("edge_lat", lat, 3); chk("edge_err", er, 1'b0);
    access(1'b1, 1'b0, 2'd2, 10'h3FC, 32'h0, 1'b1);
    chk("edge_rdata", rd, 32'h55667788);
    access(1'b0, 1'b0, 2'd2, 10'h010, 32'h0, 1'b0);
    chk("drop_lat", lat, 2); chk("drop_rdata", rd, 32'hDEADBEEF);

    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 10'h030, 32'hCAFEF00D);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!mem_we && lat < 10);
    chk("rmw_reach_write", mem_we, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_we", mem_we, 1'b0); chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_addr", mem_addr, 10'h0); chk("rst_async_wdata", mem_wdata, 32'h0);
    chk("rst_async_rdata", {p0.rdata, p1.rdata}, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    oa = 0;
    repeat (3) begin @(negedge clk); oa += int'(p0.ack) + int'(p1.ack); end
    chk("rst_no_ack", oa, 0);
    reset = 1'b0;
    access(1'b1, 1'b0, 2'd2, 10'h030, 32'h0, 1'b1);
    chk("rst_p1_lat", lat, 2); chk("rst_p1_rdata", rd, 32'h0);

    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 2'd2, 10'h010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 10'h020, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seq = 4'h0; n = 0; dual = 0; t = 0;
    while (n < 4 && t < 40) begin
      @(negedge clk);
      t++;
      if (p0.ack & p1.ack) dual++;
      if (p0.ack | p1.ack) begin seq = {seq[2:0], p1.ack}; n++; end
    end
    chk("cont_n", n, 4); chk("cont_order", seq, 4'b0101); chk("cont_dual", dual, 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    repeat (6) @(negedge clk);

    drive(1'b0, 1'b1, 1'b0, 2'd2, 10'h010, 32'h0);
    n = 0; t = 0; idle_n = 0;
    while (n < 3 && t < 30) begin
      @(negedge clk);
      t++;
      if (n >= 1 && !busy) idle_n++;
      if (p0.ack) begin ack_t[n] = t; n++; end
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    chk("b2b_n", n, 3); chk("b2b_gap1", ack_t[1] - ack_t[0], 3); chk("b2b_gap2", ack_t[2] - ack_t[1], 3);
    chk("b2b_idle", idle_n, 2);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    free = cyc + 1; last_w = 1; we_seen = 0; we_exp = 0;
    for (int k = 0; k < 2; k++) begin rq[k].v = 0; gap[k] = $urandom_range(0, 3); end
    for (int i = 0; i < 3040; i++) begin
      @(negedge clk);
      monitor();
      for (int k = 0; k < 2; k++) begin
        if (rq[k].v && cyc - rq[k].start > 20) begin
          chk("rnd_ack_wait", cyc - rq[k].start, 20);
          rq[k].v = 0;
          drive(k[0], 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
        end
        if (i < 3000 && !rq[k].v) begin
          if (gap[k] > 0) gap[k]--;
          else begin
            r = $urandom_range(0, 15);
            rq[k].addr = r == 0 ? 10'(1021 + $urandom_range(0, 2)) : r < 9 ? 10'(256 + $urandom_range(0, 15)) : 10'(256 + $urandom_range(0, 255));
            rq[k].we = 1'($urandom_range(0, 1));
            rq[k].size = 2'($urandom_range(0, 3));
            rq[k].wdata = $urandom;
            rq[k].start = cyc + 1;
            rq[k].v = 1;
            drive(k[0], 1'b1, rq[k].we, rq[k].size, rq[k].addr, rq[k].wdata);
          end
        end
      end
    end
    chk("rnd_drained", rq[0].v | rq[1].v, 1'b0);
    chk("rnd_we_pulses", we_seen, we_exp);
    diffs = 0;
    for (int i = 256; i < 520; i++) if (dmem[i] !== ref_mem[i]) diffs++;
    chk("rnd_mem_image", diffs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
